// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array slice: feed FSM encoding and width helpers.
package systolic_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } state_e;

    function automatic int unsigned calc_kw(input int unsigned k_max);
        return $clog2(k_max);
    endfunction

    // Counter must reach K_MAX + 2N - 3, the last RUN cycle of the longest pass.
    function automatic int unsigned calc_cw(input int unsigned k_max, input int unsigned n);
        return $clog2(k_max + 2 * n);
    endfunction

endpackage

// File: rtl/skew_lane.sv
// One skewed operand lane: enabled while OFFSET <= t < OFFSET + k, index = t - OFFSET.
module skew_lane #(
    parameter int unsigned OFFSET = 0,
    parameter int unsigned KW     = 4,
    parameter int unsigned CW     = 5
) (
    input  logic          run,
    input  logic [CW-1:0] t,
    input  logic [KW:0]   k,
    output logic          en,
    output logic [KW-1:0] idx
);

    localparam logic [CW:0] OffsetW = (CW + 1)'(OFFSET);

    logic [CW:0] t_ext;
    logic [CW:0] k_ext;
    logic [CW:0] rel;

    always_comb begin
        t_ext = {1'b0, t};
        k_ext = (CW + 1)'(k);
        rel   = t_ext - OffsetW;
        // rel is only meaningful once t has reached the offset
        en    = run && (t_ext >= OffsetW) && (rel < k_ext);
        idx   = en ? rel[KW-1:0] : '0;
    end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Sequences one systolic matmul pass: accumulator clear, skewed A/B operand feed, drain, done.
module systolic_feed_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned K_MAX = 16,
    parameter int unsigned KW    = calc_kw(K_MAX),
    parameter int unsigned CW    = calc_cw(K_MAX, N)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [KW:0]     k_len,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            array_clear,
    output logic [N-1:0]    a_en,
    output logic [N*KW-1:0] a_idx,
    output logic [N-1:0]    b_en,
    output logic [N*KW-1:0] b_idx
);

    localparam logic [KW:0]   KMaxW = (KW + 1)'(K_MAX);
    localparam logic [CW-1:0] SkewW = CW'(2 * (N - 1));

    state_e        state_q, state_d;
    logic [CW-1:0] t_q, t_d;
    logic [KW:0]   k_q, k_d;
    logic [CW-1:0] t_last;
    logic          run;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            t_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            k_q     <= k_d;
        end
    end

    // Only used in RUN, where k_q >= 1, so the subtraction cannot underflow.
    assign t_last = CW'(k_q) + SkewW - CW'(1);

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        k_d     = k_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    k_d     = (k_len > KMaxW) ? KMaxW : k_len;
                    state_d = StClear;
                end
            end
            StClear: begin
                t_d = '0;
                if (abort) begin
                    state_d = StIdle;
                end else if (k_q == '0) begin
                    state_d = StDone;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    t_d     = '0;
                end else if (t_q == t_last) begin
                    state_d = StDone;
                    t_d     = '0;
                end else begin
                    t_d = t_q + CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                t_d     = '0;
            end
        endcase
    end

    always_comb begin
        busy        = (state_q != StIdle);
        done        = (state_q == StDone);
        array_clear = (state_q == StClear);
        run         = (state_q == StRun);
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_lane #(
            .OFFSET (i),
            .KW     (KW),
            .CW     (CW)
        ) u_a_lane (
            .run (run),
            .t   (t_q),
            .k   (k_q),
            .en  (a_en[i]),
            .idx (a_idx[i*KW +: KW])
        );

        skew_lane #(
            .OFFSET (i),
            .KW     (KW),
            .CW     (CW)
        ) u_b_lane (
            .run (run),
            .t   (t_q),
            .k   (k_q),
            .en  (b_en[i]),
            .idx (b_idx[i*KW +: KW])
        );
    end

endmodule
